// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch control stage and its environment:
// raw buttons, mode and chain flag in; tick, direction, load pulse and status out.
interface stopwatch_ctrl_if;
    logic btn_start;
    logic btn_clear;
    logic mode_dn;
    logic chain_term;
    logic tick_en;
    logic up_dn;
    logic cnt_reset;
    logic running;
    logic done;

    modport master (
        output btn_start, btn_clear, mode_dn, chain_term,
        input  tick_en, up_dn, cnt_reset, running, done
    );

    modport slave (
        input  btn_start, btn_clear, mode_dn, chain_term,
        output tick_en, up_dn, cnt_reset, running, done
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces start/clear buttons, runs IDLE/RUN/PAUSE/DONE
// and drives the count-enable tick, direction and load pulse of the BCD digit chain.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned DB_CYCLES = 2000000
) (
    input logic              clk,
    input logic              reset,
    stopwatch_ctrl_if.slave  sw
);
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned NB  = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

    // Index 0 = start button, index 1 = clear button
    logic [NB-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]  lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
    logic [DBW-1:0] db_cnt_q [NB];
    logic [DBW-1:0] db_cnt_d [NB];
    logic [NB-1:0]  press_c;

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick_en_q, tick_en_d;
    logic           up_dn_q, up_dn_d;
    logic           cnt_reset_q, cnt_reset_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    logic           start_ev_c, clear_ev_c;

    // Synchronise and debounce both buttons; a level change needs DB_CYCLES stable cycles
    always_comb begin
        sync1_d    = {sw.btn_clear, sw.btn_start};
        sync2_d    = sync1_q;
        lvl_prev_d = lvl_q;
        lvl_d      = lvl_q;
        for (int i = 0; i < NB; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign press_c    = lvl_q & ~lvl_prev_q;
    assign start_ev_c = press_c[0];
    assign clear_ev_c = press_c[1];

    // Next state and registered outputs; clear takes priority over start everywhere
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tick_en_d   = 1'b0;
        up_dn_d     = up_dn_q;
        cnt_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_ev_c) begin
                    cnt_reset_d = 1'b1;
                end else if (start_ev_c) begin
                    state_d = ST_RUN;
                    up_dn_d = ~sw.mode_dn;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (clear_ev_c) begin
                    state_d     = ST_IDLE;
                    presc_d     = '0;
                    cnt_reset_d = 1'b1;
                end else if (start_ev_c) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    // Counting down and the whole chain reads zero: stop without a tick
                    if (!up_dn_q && sw.chain_term) begin
                        state_d = ST_DONE;
                    end else begin
                        tick_en_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (clear_ev_c) begin
                    state_d     = ST_IDLE;
                    presc_d     = '0;
                    cnt_reset_d = 1'b1;
                end else if (start_ev_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear_ev_c) begin
                    state_d     = ST_IDLE;
                    presc_d     = '0;
                    cnt_reset_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // cnt_reset resets high so the counters load at power-up and on any reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            lvl_prev_q  <= '0;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            tick_en_q   <= 1'b0;
            up_dn_q     <= 1'b1;
            cnt_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_prev_d;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_en_q   <= tick_en_d;
            up_dn_q     <= up_dn_d;
            cnt_reset_q <= cnt_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign sw.tick_en   = tick_en_q;
    assign sw.up_dn     = up_dn_q;
    assign sw.cnt_reset = cnt_reset_q;
    assign sw.running   = running_q;
    assign sw.done      = done_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3 (press latency 6 edges).
module tb_stopwatch_ctrl;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned DB_CYCLES = 3;

    localparam int SEL_RUN  = 0;
    localparam int SEL_TICK = 1;
    localparam int SEL_DONE = 2;
    localparam int SEL_CRST = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   tick_total = 0;
    int   n;
    int   snap;

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw_bus ();

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk   (clk),
        .reset (rst_n),
        .sw    (sw_bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get(input int sel);
        case (sel)
            SEL_RUN:  return sw_bus.running;
            SEL_TICK: return sw_bus.tick_en;
            SEL_DONE: return sw_bus.done;
            SEL_CRST: return sw_bus.cnt_reset;
            default:  return 1'b0;
        endcase
    endfunction

    // Advance one edge and sample just after it; every tick is seen exactly once here
    task automatic step();
        @(posedge clk);
        #1;
        if (sw_bus.tick_en === 1'b1) tick_total++;
    endtask

    task automatic wait_for(input int sel, input logic val, input int bound, output int cnt);
        cnt = 0;
        while (get(sel) !== val && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    // Mid-cycle invariants while out of reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("tick_with_cnt_reset", 32'(sw_bus.tick_en & sw_bus.cnt_reset), 0);
            check("tick_outside_run", 32'(sw_bus.tick_en & ~sw_bus.running), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        sw_bus.btn_start  = 1'b0;
        sw_bus.btn_clear  = 1'b0;
        sw_bus.mode_dn    = 1'b0;
        sw_bus.chain_term = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_cnt_reset", 32'(sw_bus.cnt_reset), 1);
        check("rst_tick_en",   32'(sw_bus.tick_en), 0);
        check("rst_up_dn",     32'(sw_bus.up_dn), 1);
        check("rst_running",   32'(sw_bus.running), 0);
        check("rst_done",      32'(sw_bus.done), 0);
        #20 rst_n = 1'b1;
        #1;
        check("cnt_reset_before_edge", 32'(sw_bus.cnt_reset), 1);
        step();
        check("cnt_reset_after_edge", 32'(sw_bus.cnt_reset), 0);
        check("idle_running", 32'(sw_bus.running), 0);

        // 2-cycle glitch is shorter than DB_CYCLES
        sw_bus.btn_start = 1'b1;
        step(); step();
        sw_bus.btn_start = 1'b0;
        repeat (10) step();
        check("glitch_no_start", 32'(sw_bus.running), 0);

        // Real press, up mode
        sw_bus.btn_start = 1'b1;
        wait_for(SEL_RUN, 1'b1, 20, n);
        check("start_latency", n, 6);
        check("up_dn_up", 32'(sw_bus.up_dn), 1);
        wait_for(SEL_TICK, 1'b1, 10, n);
        check("first_tick_delay", n, 4);
        sw_bus.btn_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("tick_width", 32'(sw_bus.tick_en), 0);
            wait_for(SEL_TICK, 1'b1, 10, n);
            check("tick_period", n, 3);
        end

        // Pause right after a tick: one more tick (edge +4), pause acts at +6 with prescaler=1
        snap = tick_total;
        sw_bus.btn_start = 1'b1;
        wait_for(SEL_RUN, 1'b0, 20, n);
        check("pause_latency", n, 6);
        check("ticks_before_pause", tick_total - snap, 1);
        repeat (2) step();
        sw_bus.btn_start = 1'b0;
        snap = tick_total;
        repeat (20) step();
        check("pause_no_ticks", tick_total - snap, 0);
        check("pause_running", 32'(sw_bus.running), 0);

        // Resume: RUN at +6, then 4-1=3 more edges to the next tick
        sw_bus.btn_start = 1'b1;
        wait_for(SEL_TICK, 1'b1, 30, n);
        check("resume_phase", n, 9);
        sw_bus.btn_start = 1'b0;
        repeat (8) step();

        // Start and clear together in RUN: clear wins
        sw_bus.btn_start = 1'b1;
        sw_bus.btn_clear = 1'b1;
        wait_for(SEL_CRST, 1'b1, 20, n);
        check("both_latency", n, 6);
        check("both_running", 32'(sw_bus.running), 0);
        check("both_tick", 32'(sw_bus.tick_en), 0);
        check("both_done", 32'(sw_bus.done), 0);
        step();
        check("both_cnt_reset_pulse", 32'(sw_bus.cnt_reset), 0);
        sw_bus.btn_start = 1'b0;
        sw_bus.btn_clear = 1'b0;
        repeat (10) step();
        check("both_stays_idle", 32'(sw_bus.running), 0);

        // Down mode reaching zero
        sw_bus.mode_dn = 1'b1;
        sw_bus.btn_start = 1'b1;
        wait_for(SEL_RUN, 1'b1, 20, n);
        check("down_start_latency", n, 6);
        check("up_dn_down", 32'(sw_bus.up_dn), 0);
        sw_bus.btn_start = 1'b0;
        wait_for(SEL_TICK, 1'b1, 10, n);
        check("down_first_tick", n, 4);
        sw_bus.chain_term = 1'b1;
        snap = tick_total;
        wait_for(SEL_DONE, 1'b1, 10, n);
        check("done_delay", n, 4);
        check("done_running", 32'(sw_bus.running), 0);
        check("done_no_tick", tick_total - snap, 0);
        repeat (6) step();
        sw_bus.btn_start = 1'b1;
        repeat (8) step();
        sw_bus.btn_start = 1'b0;
        repeat (8) step();
        check("done_ignores_start", 32'(sw_bus.done), 1);
        check("done_ignores_start_run", 32'(sw_bus.running), 0);
        sw_bus.btn_clear = 1'b1;
        wait_for(SEL_CRST, 1'b1, 20, n);
        check("done_clear_latency", n, 6);
        check("done_cleared", 32'(sw_bus.done), 0);
        step();
        check("done_clear_pulse", 32'(sw_bus.cnt_reset), 0);
        sw_bus.btn_clear = 1'b0;
        repeat (8) step();
        check("up_dn_held_in_idle", 32'(sw_bus.up_dn), 0);

        // Up mode ignores chain_term
        sw_bus.mode_dn = 1'b0;
        sw_bus.btn_start = 1'b1;
        wait_for(SEL_RUN, 1'b1, 20, n);
        check("up2_start_latency", n, 6);
        check("up2_up_dn", 32'(sw_bus.up_dn), 1);
        sw_bus.btn_start = 1'b0;
        wait_for(SEL_TICK, 1'b1, 10, n);
        check("up2_first_tick", n, 4);
        for (int k = 0; k < 3; k++) begin
            step();
            wait_for(SEL_TICK, 1'b1, 10, n);
            check("up2_tick_period", n, 3);
        end
        check("up2_not_done", 32'(sw_bus.done), 0);

        // Asynchronous reset in RUN
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_running", 32'(sw_bus.running), 0);
        check("mid_rst_cnt_reset", 32'(sw_bus.cnt_reset), 1);
        check("mid_rst_tick", 32'(sw_bus.tick_en), 0);
        check("mid_rst_up_dn", 32'(sw_bus.up_dn), 1);
        check("mid_rst_done", 32'(sw_bus.done), 0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_cnt_reset", 32'(sw_bus.cnt_reset), 0);
        check("post_rst_running", 32'(sw_bus.running), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
